// File: rtl/dmem_resp_if.sv
// Core-to-data-memory request/response bundle.
// The core drives the master side; dmem_resp sits on the slave side.
interface dmem_resp_if;
    logic        load_en;
    logic        store_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output load_en, store_en, funct3, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  load_en, store_en, funct3, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane word RAM with programmable wait states,
// sign/zero-extended loads, and done/err completion pulses for a stalled core.
module dmem_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_resp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              load_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W+1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              done_reg;
    logic              err_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       rdata_next;

    logic              req;
    logic              access;
    logic              acc_load;
    logic [2:0]        acc_funct3;
    logic [ADDR_W+1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              store_fire;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;

    function automatic logic access_err(input logic ld, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic bad;
        bad = 1'b1;
        if (ld) begin
            case (f3)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = a[0];
                3'b010:         bad = (a != 2'b00);
                default:        bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = a[0];
                3'b010:  bad = (a != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0, h};
            3'b010:  r = w;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign req = bus.load_en | bus.store_en;

    // With zero wait states the access happens on the request edge itself,
    // so the live request fields feed the RAM instead of the latched copies.
    assign acc_load   = (state_reg == IDLE) ? bus.load_en          : load_reg;
    assign acc_funct3 = (state_reg == IDLE) ? bus.funct3           : funct3_reg;
    assign acc_addr   = (state_reg == IDLE) ? bus.addr[ADDR_W+1:0] : addr_reg;
    assign acc_wdata  = (state_reg == IDLE) ? bus.wdata            : wdata_reg;

    assign access = rst_n &&
                    (((state_reg == IDLE) && req && (WAIT_CYC == 0)) ||
                     ((state_reg == BUSY) && (cnt_reg == 4'd1)));
    assign acc_err    = access_err(acc_load, acc_funct3, acc_addr[1:0]);
    assign store_fire = access && !acc_load && !acc_err;
    assign word_idx   = acc_addr[ADDR_W+1:2];

    // One 8-bit RAM per byte lane keeps partial stores as plain lane enables.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        localparam logic [1:0] LANE = 2'(gi);

        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte_reg;
        logic [7:0] lane_wdata;
        logic       lane_we;

        always_comb begin
            lane_wdata = acc_wdata[7:0];
            if (acc_funct3 == 3'b010)
                lane_wdata = acc_wdata[8*gi +: 8];
            else if (acc_funct3 == 3'b001)
                lane_wdata = acc_wdata[8*(gi%2) +: 8];
        end

        assign lane_we = store_fire &&
                         ((acc_funct3 == 3'b010) ||
                          ((acc_funct3 == 3'b001) && (acc_addr[1] == LANE[1])) ||
                          ((acc_funct3 == 3'b000) && (acc_addr[1:0] == LANE)));

        always_ff @(posedge clk) begin
            if (lane_we)
                mem[word_idx] <= lane_wdata;
            rd_byte_reg <= mem[word_idx];
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    // Load result is presented during DONE and then held by rdata_reg.
    always_comb begin
        rdata_next = rdata_reg;
        if (done_reg && load_reg)
            rdata_next = err_reg ? 32'h0 : load_ext(rd_word, addr_reg[1:0], funct3_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            load_reg   <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'h0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= 32'h0;
        end else begin
            done_reg  <= access;
            err_reg   <= access && acc_err;
            rdata_reg <= rdata_next;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        load_reg   <= bus.load_en;
                        funct3_reg <= bus.funct3;
                        addr_reg   <= bus.addr[ADDR_W+1:0];
                        wdata_reg  <= bus.wdata;
                        cnt_reg    <= 4'(WAIT_CYC);
                        state_reg  <= (WAIT_CYC == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.stall = ((state_reg == IDLE) && req) || (state_reg == BUSY);
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;
    assign bus.rdata = rdata_next;
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp (ADDR_W=10, WAIT_CYC=2): stores, extended loads,
// error pulses, address aliasing, and reset in the middle of an access.
module tb_dmem_resp;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   miscmp_cnt;

    dmem_resp_if bus ();

    dmem_resp #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Issues one request at a negedge and holds it until done is seen.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er,
                              output int lat, output int stl);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        stl  = 0;
        rd   = 32'h0;
        er   = 1'b0;
        bus.load_en  = ld;
        bus.store_en = st;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata    = wd;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.stall) stl++;
            if (bus.done) begin
                rd   = bus.rdata;
                er   = bus.err;
                lat  = n;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 32'(seen), 32'd1);
        bus.load_en  = 1'b0;
        bus.store_en = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stl;
    int          done_pulses;

    initial begin
        vec_cnt      = 0;
        miscmp_cnt   = 0;
        rst_n        = 1'b0;
        bus.load_en  = 1'b0;
        bus.store_en = 1'b0;
        bus.funct3   = 3'b000;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_done_err_stall", {29'h0, bus.done, bus.err, bus.stall}, 32'h0);

        run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, stl);
        check("sw_latency", 32'(lat), 32'd3);
        check("sw_stall_cycles", 32'(stl), 32'd3);
        check("sw_err", {31'h0, er}, 32'h0);

        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_latency", 32'(lat), 32'd3);
        check("lw_stall_cycles", 32'(stl), 32'd3);
        #1;
        check("done_one_cycle", {31'h0, bus.done}, 32'h0);
        check("rdata_held", bus.rdata, 32'hDEADBEEF);

        run_access(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF80, rd, er, lat, stl);
        run_access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat, stl);
        check("lb_sext", rd, 32'hFFFFFF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, rd, er, lat, stl);
        check("lbu_zext", rd, 32'h00000080);
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("sb_word", rd, 32'hDEAD80EF);

        run_access(1'b0, 1'b1, 3'b001, 32'h12, 32'hABCD1234, rd, er, lat, stl);
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("sh_word", rd, 32'h123480EF);
        run_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, stl);
        check("lh_hi", rd, 32'h00001234);
        run_access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, rd, er, lat, stl);
        check("lh_lo_sext", rd, 32'hFFFF80EF);
        run_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat, stl);
        check("lhu_lo_zext", rd, 32'h000080EF);
        run_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat, stl);
        check("lb_lane3", rd, 32'h00000012);

        run_access(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, rd, er, lat, stl);
        check("lw_misalign_err", {31'h0, er}, 32'h1);
        check("lw_misalign_rdata", rd, 32'h0);
        check("err_latency", 32'(lat), 32'd3);
        run_access(1'b1, 1'b0, 3'b001, 32'h01, 32'h0, rd, er, lat, stl);
        check("lh_misalign_err", {31'h0, er}, 32'h1);
        check("lh_misalign_rdata", rd, 32'h0);
        run_access(1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, rd, er, lat, stl);
        check("sh_misalign_err", {31'h0, er}, 32'h1);
        run_access(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, er, lat, stl);
        check("store_illegal_err", {31'h0, er}, 32'h1);
        run_access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, stl);
        check("load_illegal_err", {31'h0, er}, 32'h1);
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("ram_unchanged", rd, 32'h123480EF);
        check("good_load_no_err", {31'h0, er}, 32'h0);

        run_access(1'b0, 1'b1, 3'b010, 32'h1010, 32'hA5A5A5A5, rd, er, lat, stl);
        check("store_keeps_rdata", rd, 32'h123480EF);
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("alias_lw", rd, 32'hA5A5A5A5);

        run_access(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("both_load_wins", rd, 32'hA5A5A5A5);
        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, stl);
        check("both_store_dropped", rd, 32'hA5A5A5A5);

        run_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h55667788, rd, er, lat, stl);
        bus.store_en = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h20;
        bus.wdata    = 32'h00000001;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.store_en = 1'b0;
        #1;
        check("rst_busy_stall", {31'h0, bus.stall}, 32'h0);
        check("rst_busy_rdata", bus.rdata, 32'h0);
        done_pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            #1;
            if (bus.done) done_pulses++;
        end
        check("rst_busy_no_done", 32'(done_pulses), 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, stl);
        check("rst_busy_old_data", rd, 32'h55667788);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule
